debounce_sync: RTL and testbench
================================

Name: debounce_sync

Overview:
- Conditions a raw asynchronous, bouncy input (push-button or switch) into a clean, clock-synchronous level.
- Also produces single-cycle rise/fall pulses.
- Sits directly upstream of the d_ff/register stages and drives their d input with a stable, metastability-safe signal.
- Structure: synchronizer chain, then a 4-state debounce FSM with a stability counter.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles the synchronized input must hold a new value before dout changes; legal range 2..255.
- CNT_W (localparam), $clog2(STABLE_CYCLES+1), counter width; not overridable.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  raw asynchronous input (bouncy).
- dout  output  1  debounced, synchronized level (registered).
- rise  output  1  one-cycle pulse, high in the cycle dout goes 0->1 (registered).
- fall  output  1  one-cycle pulse, high in the cycle dout goes 1->0 (registered).

Behaviour:
- Reset (asynchronous, immediate, no clock needed):
  - Synchronizer flops = 0, state = IDLE_LOW, cnt = 0.
  - dout = 0, rise = 0, fall = 0.
- Synchronizer: 2 flops, s1 <= din, s2 <= s1. FSM sees only s2.
- States: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - IDLE_LOW: s2=1 -> WAIT_HIGH, cnt=1; else stay, cnt=0.
  - WAIT_HIGH: s2=0 -> IDLE_LOW, cnt=0 (glitch rejected, no pulse). s2=1 and cnt==STABLE_CYCLES-1 -> IDLE_HIGH, dout<=1, rise<=1, cnt=0. Otherwise cnt++.
  - IDLE_HIGH: s2=0 -> WAIT_LOW, cnt=1; else stay.
  - WAIT_LOW: mirror of WAIT_HIGH (s2=1 -> IDLE_HIGH; completion -> IDLE_LOW, dout<=0, fall<=1).
- rise/fall are high for exactly one cycle, are mutually exclusive, and are never asserted during or in the first cycle after reset.
- Latency:
  - Let edge k be the first clk edge that samples the new din value into s1.
  - dout changes at edge k+STABLE_CYCLES+1 (edge k+5 for the default).
  - The pulse is coincident with the dout change.
- Any reversal of s2 during WAIT_* restarts the count from the idle state, so a change needs STABLE_CYCLES uninterrupted cycles.
- cnt never exceeds STABLE_CYCLES-1, so no wrap-around.
- Reset released while din=1: the block starts from IDLE_LOW and produces a normal rise after the latency above. There is no special case.
- Reset asserted mid-WAIT: all state is cleared immediately and the partial count is discarded.

Optional Feature:
- Macro: SYNC3_EN.
- Defined: the synchronizer is 3 flops (s1->s2->s3) and the FSM sees s3. Latency becomes edge k+STABLE_CYCLES+2. All other behaviour is unchanged.
- Undefined: the 2-flop synchronizer as specified above.

Decomposition:
- Package debounce_pkg:
  - state typedef (enum of the 4 states, 2-bit encoding IDLE_LOW=0, WAIT_HIGH=1, IDLE_HIGH=2, WAIT_LOW=3).
  - localparam SYNC_DEPTH (2, or 3 under SYNC3_EN).
- Sub-module sync_ff_chain:
  - Parameterized by depth; same clk/rst (async, active-high, reset to 0).
  - Instantiated once for din.
- The FSM, counter and pulse registers live in debounce_sync.

Test Plan (STABLE_CYCLES=4, clk period 10, forever #5 clk=~clk):
- rst=1 with din=1 for 3 cycles -> dout=0, rise=0, fall=0 throughout. After rst drops, dout=1 at the 6th edge after release and rise=1 for exactly that one cycle.
- From IDLE_LOW, din 0->1 just after edge 0 -> dout=1 after edge 6. rise high only between edges 6 and 7, fall stays 0.
- Glitch: din=1 for 2 cycles then 0 -> dout stays 0 and no pulses. The FSM returns to IDLE_LOW (state=0) with cnt=0.
- Bounce: din toggles every 2 cycles for 10 cycles, then holds 1 -> dout=1 exactly 5 edges after the first edge that samples the final 1. A single rise pulse.
- Fall: with dout=1 steady, din 1->0 -> dout=0 after 5 edges past the sampling edge. fall is a one-cycle pulse, rise stays 0.
- Async reset mid-WAIT_HIGH (cnt=2): pulse rst at t=+3 after an edge -> state, cnt and outputs clear before the next edge. With din still 1 after release, the full latency is required again.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and build-time constants for the debounce_sync block.
// Define SYNC3_EN to lengthen the input synchronizer from 2 to 3 flops.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

`ifdef SYNC3_EN
    localparam int SYNC_DEPTH = 3;
`else
    localparam int SYNC_DEPTH = 2;
`endif

endpackage

// File: rtl/debounce_sync_sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; every stage resets to 0.
module sync_ff_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_d[gi] = din;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[DEPTH-1];

endmodule

// File: rtl/debounce_sync.sv
// Debounces a bouncy asynchronous input into a clean level plus rise/fall pulses.
// Synchronizer depth follows SYNC3_EN through debounce_pkg::SYNC_DEPTH.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             din_sync;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_ff_chain #(
        .DEPTH (SYNC_DEPTH)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (din_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (din_sync) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                // Any reversal drops back to idle so the count always restarts from scratch.
                if (!din_sync) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!din_sync) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (din_sync) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: vector table, corner-case sequences and
// randomized input against a run-length reference model.
module tb_debounce_sync;
    import debounce_pkg::*;

    localparam int STABLE = 4;
    localparam int LAT    = STABLE + SYNC_DEPTH;  // edges from first sampling edge (=1) to dout change

    logic clk;
    logic rst;
    logic din;
    logic dout;
    logic rise;
    logic fall;

    int checks;
    int errors;

    // Reference model: delay line for the synchronizer, then count consecutive
    // samples that disagree with the current level; flip after STABLE of them.
    int pipe [SYNC_DEPTH];
    int exp_dout;
    int exp_rise;
    int exp_fall;
    int run_len;

    typedef struct {
        logic d;
        int   e_dout;
        int   e_rise;
        int   e_fall;
    } vec_t;

    vec_t vecs [16];

    debounce_sync #(
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SYNC_DEPTH; i++) pipe[i] = 0;
        exp_dout = 0;
        exp_rise = 0;
        exp_fall = 0;
        run_len  = 0;
    endtask

    task automatic model_edge();
        int seen;
        seen = pipe[SYNC_DEPTH-1];
        for (int i = SYNC_DEPTH - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = int'(din);
        exp_rise = 0;
        exp_fall = 0;
        if (seen != exp_dout) begin
            run_len++;
            if (run_len == STABLE) begin
                exp_dout = seen;
                exp_rise = seen;
                exp_fall = 1 - seen;
                run_len  = 0;
            end
        end else begin
            run_len = 0;
        end
    endtask

    // One clock: advance the model at the edge, compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        chk("model_dout", int'(dout), exp_dout);
        chk("model_rise", int'(rise), exp_rise);
        chk("model_fall", int'(fall), exp_fall);
    endtask

    initial begin
        int first_edge;
        int rise_cnt;
        int hold;

        checks = 0;
        errors = 0;
        model_reset();

        // Rise then fall: din high for 8 edges, then low for 8 edges.
        for (int i = 0; i < 16; i++) begin
            vecs[i].d      = (i < 8) ? 1'b1 : 1'b0;
            vecs[i].e_dout = (i >= LAT - 1 && i < 8 + LAT - 1) ? 1 : 0;
            vecs[i].e_rise = (i == LAT - 1) ? 1 : 0;
            vecs[i].e_fall = (i == 8 + LAT - 1) ? 1 : 0;
        end

        // Reset held with din=1: outputs stay low throughout.
        rst = 1'b1;
        din = 1'b1;
        #1;
        chk("rst_async_dout", int'(dout), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_dout", int'(dout), 0);
            chk("rst_rise", int'(rise), 0);
            chk("rst_fall", int'(fall), 0);
        end
        rst = 1'b0;
        for (int i = 1; i <= LAT + 1; i++) begin
            step();
            chk("post_rst_dout", int'(dout), (i >= LAT) ? 1 : 0);
            chk("post_rst_rise", int'(rise), (i == LAT) ? 1 : 0);
        end

        din = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Vector table.
        for (int i = 0; i < 16; i++) begin
            din = vecs[i].d;
            step();
            chk("vec_dout", int'(dout), vecs[i].e_dout);
            chk("vec_rise", int'(rise), vecs[i].e_rise);
            chk("vec_fall", int'(fall), vecs[i].e_fall);
        end

        // Glitch: two cycles high are rejected.
        din = 1'b1;
        step();
        step();
        din = 1'b0;
        rise_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            rise_cnt += int'(rise) + int'(fall) + int'(dout);
        end
        chk("glitch_activity", rise_cnt, 0);
        chk("glitch_state", int'(dut.state_q), int'(IDLE_LOW));
        chk("glitch_cnt", int'(dut.cnt_q), 0);

        // Bounce: toggle every 2 cycles for 10 cycles, then hold high.
        first_edge = -1;
        rise_cnt   = 0;
        for (int i = 0; i < 20; i++) begin
            din = (i >= 10 || ((i / 2) % 2) == 0) ? 1'b1 : 1'b0;
            step();
            if (dout && first_edge < 0) first_edge = i;
            rise_cnt += int'(rise);
        end
        chk("bounce_edge", first_edge, 8 + LAT - 1);
        chk("bounce_rises", rise_cnt, 1);

        din = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("settle_low", int'(dout), 0);

        // Asynchronous reset in the middle of WAIT_HIGH with cnt=2.
        din = 1'b1;
        for (int i = 0; i < SYNC_DEPTH + 2; i++) step();
        chk("midwait_state", int'(dut.state_q), int'(WAIT_HIGH));
        chk("midwait_cnt", int'(dut.cnt_q), 2);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_state", int'(dut.state_q), int'(IDLE_LOW));
        chk("arst_cnt", int'(dut.cnt_q), 0);
        chk("arst_dout", int'(dout), 0);
        rst = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            step();
            chk("relatch_dout", int'(dout), (i >= LAT) ? 1 : 0);
        end

        // Randomized hold lengths against the model.
        hold = 0;
        for (int n = 0; n < 800; n++) begin
            if (hold == 0) begin
                din  = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 8));
            end
            hold--;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
